pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic elastic pipeline-stage register that replaces the fixed, always-advancing inter-stage registers of the 8-bit pipeline. It carries a parametrised data bundle and a control bundle between two stages. Flow control uses valid/ready. An optional 2-entry skid buffer breaks the ready timing path. A synchronous flush turns all held entries into bubbles; a bubble has its control fields forced to zero.

Parameters:
DATA_W, 16, width of the data bundle (ALU result, store data, rd, flags, ...)
CTRL_W, 5, width of the control bundle (memread, memwrite, memtoreg, regwrite, branch, ...)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
clk  input  1  clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush; invalidates all entries this cycle
in_valid  input  1  upstream has a valid entry
in_ready  output  1  stage can accept an entry this cycle
in_data  input  DATA_W  upstream data bundle
in_ctrl  input  CTRL_W  upstream control bundle
out_valid  output  1  stage holds a valid entry for downstream
out_ready  input  1  downstream accepts the entry this cycle
out_data  output  DATA_W  data of head entry
out_ctrl  output  CTRL_W  control of head entry; all zero when out_valid=0
occupancy  output  2  number of valid entries held (0..2; max 1 when SKID=0)

Behaviour:
- Clock and reset: clk is the only clock. reset_n is asynchronous and active-low.
- Reset values: all valid bits 0, data/ctrl storage 0, out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
- in_ready during and after reset: 1 when SKID=1 (it is !skid_valid); 1 when SKID=0.
- Transfer rules:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
  - in_data/in_ctrl are ignored when no input transfer occurs.
- Bubble gating: out_ctrl = ctrl_q when out_valid=1, otherwise 0. out_data holds its last value when invalid; it is not zeroed.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - On an input transfer, main <= input and valid <= 1.
  - On an output transfer with no input transfer, valid <= 0.
  - Latency 1 cycle. Full throughput when out_ready=1.
- SKID=1 (main = head entry, skid = overflow entry):
  - in_ready = !skid_valid, driven purely from a register.
  - Output transfer with skid valid: main <= skid and skid_valid <= 0. An input transfer in the same cycle is impossible because in_ready=0.
  - Input transfer with main empty, or with an output transfer in the same cycle and skid empty: main <= input.
  - Input transfer with main valid and no output transfer: skid <= input and skid_valid <= 1. in_ready drops next cycle.
  - Latency 1 cycle. Full throughput. Order is strictly preserved (FIFO).
- flush (highest priority):
  - All valid bits go to 0 at the edge, so out_valid=0 and out_ctrl=0 next cycle.
  - An entry presented on in_* that cycle is discarded, even if in_ready=1.
  - Any output transfer that cycle still counts as completed downstream.
  - Stored data is not cleared.
- Simultaneous input and output transfer at occupancy 1: occupancy stays 1 and the new entry becomes head.
- occupancy = main_valid + skid_valid, registered-valid based.
- Asynchronous reset mid-transfer: all entries are lost immediately and outputs return to reset values. Nothing is replayed after reset release.
- Invariant: skid_valid=1 implies main_valid=1. No overflow is possible and no entry is ever dropped except by flush or reset.

Test Plan:
- Reset: assert reset_n=0 mid-stream with occupancy=2 -> out_valid=0, out_ctrl=0, occupancy=0 immediately; in_ready=1.
- Streaming: SKID=1, out_ready=1, in_valid=1 for 8 cycles with data 0x01..0x08 -> out_data 0x01..0x08 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Backpressure: SKID=1, send 0xA1, 0xA2, 0xA3 with out_ready=0 -> occupancy 1, then 2. in_ready=0 after the second accept, so 0xA3 is held upstream. Raise out_ready -> order 0xA1, 0xA2, 0xA3 with no loss or duplication.
- Flush: occupancy=2 with ctrl=5'b11111, assert flush together with in_valid (data 0xBB) -> next cycle out_valid=0, out_ctrl=0, occupancy=0. 0xBB never appears at the output.
- SKID=0 combinational ready: out_valid=1, out_ready=0 -> in_ready=0. Set out_ready=1 in the same cycle -> in_ready=1, and the new entry replaces the head with occupancy staying 1.
- Random: random in_valid/out_ready/flush (10% flush) over 10k cycles, checked against a reference FIFO model -> order is preserved, no drops outside flush, and out_ctrl is never nonzero while out_valid=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_reg                                               |
// | Description : Elastic valid/ready pipeline-stage register carrying a data  |
// |               and a control bundle, with an optional 2-entry skid buffer.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stage_reg #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 5,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              w_skid_valid;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_main_valid && out_ready;

    generate
        if (SKID) begin : g_skid
            logic              r_skid_valid;
            logic [DATA_W-1:0] r_skid_data;
            logic [CTRL_W-1:0] r_skid_ctrl;

            // Ready comes straight from a flop so it never depends on out_ready.
            assign in_ready     = !r_skid_valid;
            assign w_skid_valid = r_skid_valid;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_main_valid <= 1'b0;
                    r_main_data  <= '0;
                    r_main_ctrl  <= '0;
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= '0;
                    r_skid_ctrl  <= '0;
                end else if (flush) begin
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                end else if (w_out_xfer && r_skid_valid) begin
                    r_main_data  <= r_skid_data;
                    r_main_ctrl  <= r_skid_ctrl;
                    r_skid_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    if (!r_main_valid || w_out_xfer) begin
                        r_main_valid <= 1'b1;
                        r_main_data  <= in_data;
                        r_main_ctrl  <= in_ctrl;
                    end else begin
                        r_skid_valid <= 1'b1;
                        r_skid_data  <= in_data;
                        r_skid_ctrl  <= in_ctrl;
                    end
                end else if (w_out_xfer) begin
                    r_main_valid <= 1'b0;
                end
            end
        end else begin : g_no_skid
            assign in_ready     = !r_main_valid || out_ready;
            assign w_skid_valid = 1'b0;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_main_valid <= 1'b0;
                    r_main_data  <= '0;
                    r_main_ctrl  <= '0;
                end else if (flush) begin
                    r_main_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= in_data;
                    r_main_ctrl  <= in_ctrl;
                end else if (w_out_xfer) begin
                    r_main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    // Bubbles must never leak control side effects downstream.
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_valid ? r_main_ctrl : '0;
    assign occupancy = {1'b0, r_main_valid} + {1'b0, w_skid_valid};

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_reg                                            |
// | Description : Scoreboard bench driving a SKID=1 and a SKID=0 instance.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_reg;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 5;
    localparam int ENT_W  = DATA_W + CTRL_W;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_ready;

    logic              in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DATA_W-1:0] out_data1, out_data0;
    logic [CTRL_W-1:0] out_ctrl1, out_ctrl0;
    logic [1:0]        occ1, occ0;

    int total = 0;
    int bad   = 0;

    logic [ENT_W-1:0] q1[$];
    logic [ENT_W-1:0] q0[$];
    logic             exp_rdy1, exp_rdy0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_ctrl(out_ctrl1), .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_ctrl(out_ctrl0), .occupancy(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: compare DUT state against the model, then retire the head on an output transfer.
    always @(negedge clk) begin
        if (reset_n) begin
            exp_rdy1 = (q1.size() < 2);
            chk("skid.in_ready", 32'(in_ready1), 32'(exp_rdy1));
            chk("skid.occupancy", 32'(occ1), 32'(q1.size()));
            chk("skid.out_valid", 32'(out_valid1), 32'(q1.size() != 0));
            if (q1.size() != 0) begin
                chk("skid.out_data", 32'(out_data1), 32'(q1[0][DATA_W-1:0]));
                chk("skid.out_ctrl", 32'(out_ctrl1), 32'(q1[0][ENT_W-1:DATA_W]));
                if (out_ready) void'(q1.pop_front());
            end else begin
                chk("skid.bubble_ctrl", 32'(out_ctrl1), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            exp_rdy0 = (q0.size() == 0) || out_ready;
            chk("noskid.in_ready", 32'(in_ready0), 32'(exp_rdy0));
            chk("noskid.occupancy", 32'(occ0), 32'(q0.size()));
            chk("noskid.out_valid", 32'(out_valid0), 32'(q0.size() != 0));
            if (q0.size() != 0) begin
                chk("noskid.out_data", 32'(out_data0), 32'(q0[0][DATA_W-1:0]));
                chk("noskid.out_ctrl", 32'(out_ctrl0), 32'(q0[0][ENT_W-1:DATA_W]));
                if (out_ready) void'(q0.pop_front());
            end else begin
                chk("noskid.bubble_ctrl", 32'(out_ctrl0), 32'd0);
            end
        end
    end

    // One cycle of stimulus; the expected entry is pushed once the model knows it is accepted.
    task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
        if (fl) begin
            q1.delete();
            q0.delete();
        end else if (iv) begin
            if (exp_rdy1) q1.push_back({c, d});
            if (exp_rdy0) q0.push_back({c, d});
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        chk("reset.out_data1", 32'(out_data1), 32'd0);
        chk("reset.out_data0", 32'(out_data0), 32'd0);

        // Streaming 0x01..0x08 at full throughput
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 5'(i), 1'b1, 1'b0);
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);

        // Backpressure: 0xA3 is held upstream until the skid entry drains
        step(1'b1, 16'h00A1, 5'h01, 1'b0, 1'b0);
        step(1'b1, 16'h00A2, 5'h02, 1'b0, 1'b0);
        step(1'b1, 16'h00A3, 5'h03, 1'b0, 1'b0);
        step(1'b1, 16'h00A3, 5'h03, 1'b1, 1'b0);
        step(1'b1, 16'h00A3, 5'h03, 1'b1, 1'b0);
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);

        // Flush with occupancy 2 and an entry offered in the same cycle
        step(1'b1, 16'h00C1, 5'h1F, 1'b0, 1'b0);
        step(1'b1, 16'h00C2, 5'h1F, 1'b0, 1'b0);
        step(1'b1, 16'h00BB, 5'h1F, 1'b0, 1'b1);
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);

        // Replace-at-head on the combinational-ready instance
        step(1'b1, 16'h00D1, 5'h0A, 1'b0, 1'b0);
        step(1'b1, 16'h00D2, 5'h0B, 1'b0, 1'b0);
        step(1'b1, 16'h00D2, 5'h0B, 1'b1, 1'b0);
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);

        // Asynchronous reset with the skid instance full
        step(1'b1, 16'h00E1, 5'h15, 1'b0, 1'b0);
        step(1'b1, 16'h00E2, 5'h0E, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("areset.occ1", 32'(occ1), 32'd0);
        chk("areset.out_valid1", 32'(out_valid1), 32'd0);
        chk("areset.out_ctrl1", 32'(out_ctrl1), 32'd0);
        chk("areset.in_ready1", 32'(in_ready1), 32'd1);
        chk("areset.occ0", 32'(occ0), 32'd0);
        chk("areset.in_ready0", 32'(in_ready0), 32'd1);
        q1.delete();
        q0.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);

        // Random traffic with ~10% flush
        for (int i = 0; i < 10000; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 5'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 5'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
